// File: rtl/dep_window_checker.sv
// dep_window_checker
//   Fetches a program of 4-word instructions (opcode, dest, src1, src2) from an
//   instruction memory, one word per cycle. It compares each instruction
//   against the previous WINDOW instructions and reports RAW/WAR/WAW hazards per
//   distance over a valid/ready channel. An END_OP opcode word ends the program.
//   If the address space runs out before END_OP, the last instruction is still
//   reported and the run ends with overflow set.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse; starts a run at address 0 (IDLE/DONE only)
//   mem_addr, mem_data  registered word address / combinational read data
//   rpt_valid/ready     report handshake
//   rpt_index           0-based index of the reported instruction
//   rpt_raw/war/waw     bit k-1 set: hazard against the instruction k back
//   busy, done          run in progress / run finished
//   overflow            run ended because the address space ran out
module dep_window_checker #(
  parameter int unsigned FIELD_W   = 4,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned WINDOW    = 3,
  parameter int unsigned END_OP    = 4,
  parameter bit          ZERO_HARD = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [FIELD_W-1:0]  mem_data,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [ADDR_W-3:0]   rpt_index,
  output logic [WINDOW-1:0]   rpt_raw,
  output logic [WINDOW-1:0]   rpt_war,
  output logic [WINDOW-1:0]   rpt_waw,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam logic [FIELD_W-1:0] END_W    = FIELD_W'(END_OP);
  localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_REPORT, S_DONE} state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] op;
    logic [FIELD_W-1:0] dest;
    logic [FIELD_W-1:0] src1;
    logic [FIELD_W-1:0] src2;
  } instr_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-3:0]   idx_q, idx_d;
  logic                ovf_pend_q, ovf_pend_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic [WINDOW-1:0]   raw_q, raw_d, war_q, war_d, waw_q, waw_d;
  logic [WINDOW-1:0]   win_vld_q, win_vld_d;
  instr_t              cur_q, cur_d;
  instr_t              win_q [WINDOW];
  instr_t              win_d [WINDOW];
  logic [WINDOW-1:0]   raw_c, war_c, waw_c;

  // Register equality; with ZERO_HARD, register 0 never matches anything.
  function automatic logic reg_match(input logic [FIELD_W-1:0] a,
                                     input logic [FIELD_W-1:0] b);
    return (a == b) && !(ZERO_HARD && (a == '0));
  endfunction

  // Hazard vector of the current instruction against every window slot;
  // slot k holds the instruction k+1 back.
  always_comb begin
    for (int k = 0; k < int'(WINDOW); k++) begin
      raw_c[k] = win_vld_q[k] && (reg_match(cur_q.src1, win_q[k].dest) ||
                                  reg_match(cur_q.src2, win_q[k].dest));
      war_c[k] = win_vld_q[k] && (reg_match(cur_q.dest, win_q[k].src1) ||
                                  reg_match(cur_q.dest, win_q[k].src2));
      waw_c[k] = win_vld_q[k] &&  reg_match(cur_q.dest, win_q[k].dest);
    end
  end

  // NOTE: every _d signal gets its hold value first so no path leaves it
  // unassigned; otherwise the combinational block would infer latches.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    valid_d    = valid_q;
    raw_d      = raw_q;
    war_d      = war_q;
    waw_d      = waw_q;
    win_vld_d  = win_vld_q;
    cur_d      = cur_q;
    win_d      = win_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FETCH;
          addr_d     = '0;
          cnt_d      = '0;
          idx_d      = '0;
          ovf_pend_d = 1'b0;
          ovf_d      = 1'b0;
          win_vld_d  = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == 2'd0 && mem_data == END_W) begin
          // Terminator word: consumed, never reported, address left in place.
          state_d = S_DONE;
        end else begin
          unique case (cnt_q)
            2'd0: cur_d.op   = mem_data;
            2'd1: cur_d.dest = mem_data;
            2'd2: cur_d.src1 = mem_data;
            2'd3: cur_d.src2 = mem_data;
          endcase
          cnt_d = cnt_q + 2'd1;
          // The address saturates at the top of memory; reaching it with the
          // last field flags the run to end after this instruction's report.
          if (addr_q == ADDR_MAX) begin
            if (cnt_q == 2'd3) ovf_pend_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          if (cnt_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        raw_d   = raw_c;
        war_d   = war_c;
        waw_d   = waw_c;
        valid_d = 1'b1;
        state_d = S_REPORT;
      end
      S_REPORT: begin
        if (rpt_ready) begin
          valid_d      = 1'b0;
          idx_d        = idx_q + (ADDR_W-2)'(1);
          win_d[0]     = cur_q;
          win_vld_d[0] = 1'b1;
          for (int k = 1; k < int'(WINDOW); k++) begin
            win_d[k]     = win_q[k-1];
            win_vld_d[k] = win_vld_q[k-1];
          end
          if (ovf_pend_q) begin
            state_d = S_DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking ones are kept to the combinational blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      raw_q      <= '0;
      war_q      <= '0;
      waw_q      <= '0;
      win_vld_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      raw_q      <= raw_d;
      war_q      <= war_d;
      waw_q      <= waw_d;
      win_vld_q  <= win_vld_d;
    end
  end

  // NOTE: instruction storage has no reset; the valid bits alone decide
  // whether a slot takes part in a compare.
  always_ff @(posedge clk) begin
    cur_q <= cur_d;
    win_q <= win_d;
  end

  assign mem_addr  = addr_q;
  assign rpt_valid = valid_q;
  assign rpt_index = idx_q;
  assign rpt_raw   = raw_q;
  assign rpt_war   = war_q;
  assign rpt_waw   = waw_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_CHECK) ||
                     (state_q == S_REPORT);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_dep_window_checker.sv
// Bench for dep_window_checker: instance A (ADDR_W=6, ZERO_HARD=0) and
// instance B (ADDR_W=4, ZERO_HARD=1). Expected reports are queued when a run
// is launched; per-instance monitors compare every presented report.
module tb_dep_window_checker;

  typedef struct {
    int idx;
    int raw;
    int war;
    int waw;
    int addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A
  logic       rst_a_n, start_a, rpt_ready_a;
  logic [5:0] mem_addr_a;
  logic [3:0] mem_data_a;
  logic       rpt_valid_a, busy_a, done_a, ovf_a;
  logic [3:0] rpt_index_a;
  logic [2:0] raw_a, war_a, waw_a;
  logic [3:0] mem_a [64];
  assign mem_data_a = mem_a[mem_addr_a];

  // Instance B
  logic       rst_b_n, start_b, rpt_ready_b;
  logic [3:0] mem_addr_b;
  logic [3:0] mem_data_b;
  logic       rpt_valid_b, busy_b, done_b, ovf_b;
  logic [1:0] rpt_index_b;
  logic [2:0] raw_b, war_b, waw_b;
  logic [3:0] mem_b [16];
  assign mem_data_b = mem_b[mem_addr_b];

  dep_window_checker #(.FIELD_W(4), .ADDR_W(6), .WINDOW(3), .END_OP(4), .ZERO_HARD(1'b0)) u_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .rpt_valid(rpt_valid_a), .rpt_ready(rpt_ready_a), .rpt_index(rpt_index_a),
    .rpt_raw(raw_a), .rpt_war(war_a), .rpt_waw(waw_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a));

  dep_window_checker #(.FIELD_W(4), .ADDR_W(4), .WINDOW(3), .END_OP(4), .ZERO_HARD(1'b1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready_b), .rpt_index(rpt_index_b),
    .rpt_raw(raw_b), .rpt_war(war_b), .rpt_waw(waw_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input int raw, input int war,
                              input int waw, input int addr);
    exp_t e;
    e.idx = idx; e.raw = raw; e.war = war; e.waw = waw; e.addr = addr;
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_a_n && rpt_valid_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_report", 1, 0);
      end else begin
        check("a_index", int'(rpt_index_a), qa[0].idx);
        check("a_raw",   int'(raw_a),       qa[0].raw);
        check("a_war",   int'(war_a),       qa[0].war);
        check("a_waw",   int'(waw_a),       qa[0].waw);
        check("a_addr_in_report", int'(mem_addr_a), qa[0].addr);
        if (rpt_ready_a) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b_n && rpt_valid_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_report", 1, 0);
      end else begin
        check("b_index", int'(rpt_index_b), qb[0].idx);
        check("b_raw",   int'(raw_b),       qb[0].raw);
        check("b_war",   int'(war_b),       qb[0].war);
        check("b_waw",   int'(waw_b),       qb[0].waw);
        check("b_addr_in_report", int'(mem_addr_b), qb[0].addr);
        if (rpt_ready_b) void'(qb.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic put_a(input int i, input int op, input int d, input int s1, input int s2);
    mem_a[4*i]   = 4'(op);
    mem_a[4*i+1] = 4'(d);
    mem_a[4*i+2] = 4'(s1);
    mem_a[4*i+3] = 4'(s2);
  endtask

  task automatic put_b(input int i, input int op, input int d, input int s1, input int s2);
    mem_b[4*i]   = 4'(op);
    mem_b[4*i+1] = 4'(d);
    mem_b[4*i+2] = 4'(s1);
    mem_b[4*i+3] = 4'(s2);
  endtask

  task automatic load_main_a();
    for (int i = 0; i < 64; i++) mem_a[i] = 4'd0;
    put_a(0, 0, 5, 0, 1);  // ADD R5,R0,R1
    put_a(1, 1, 6, 2, 5);  // MUL R6,R2,R5
    put_a(2, 2, 5, 3, 6);  // SUB R5,R3,R6
    put_a(3, 3, 6, 5, 4);  // DIV R6,R5,R4
    mem_a[16] = 4'd4;      // END
  endtask

  task automatic push_main_a();
    qa.push_back(mk(0, 0, 0, 0, 4));
    qa.push_back(mk(1, 1, 0, 0, 8));
    qa.push_back(mk(2, 1, 1, 2, 12));
    qa.push_back(mk(3, 5, 1, 2, 16));
  endtask

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (!done_a && n < 400) begin @(negedge clk); n++; end
    check("a_done", int'(done_a), 1);
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    while (!done_b && n < 400) begin @(negedge clk); n++; end
    check("b_done", int'(done_b), 1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_mem_addr"}, int'(mem_addr_a), 0);
    check({tag, "_valid"},    int'(rpt_valid_a), 0);
    check({tag, "_index"},    int'(rpt_index_a), 0);
    check({tag, "_raw"},      int'(raw_a), 0);
    check({tag, "_war"},      int'(war_a), 0);
    check({tag, "_waw"},      int'(waw_a), 0);
    check({tag, "_busy"},     int'(busy_a), 0);
    check({tag, "_done"},     int'(done_a), 0);
    check({tag, "_overflow"}, int'(ovf_a), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int w;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    rpt_ready_a = 1'b1; rpt_ready_b = 1'b1;
    for (int i = 0; i < 64; i++) mem_a[i] = 4'd0;
    for (int i = 0; i < 16; i++) mem_b[i] = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check_zero_a("a_rst");
    check("b_rst_busy", int'(busy_b), 0);
    check("b_rst_done", int'(done_b), 0);
    check("b_rst_overflow", int'(ovf_b), 0);
    check("b_rst_valid", int'(rpt_valid_b), 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Main program, consumer always ready: one report every 6 cycles.
    load_main_a();
    push_main_a();
    pulse_start_a();
    wait_done_a(n);
    check("a_main_latency", n, 26);
    check("a_main_mem_addr", int'(mem_addr_a), 16);
    check("a_main_overflow", int'(ovf_a), 0);
    check("a_main_busy", int'(busy_a), 0);
    check("a_main_q_empty", qa.size(), 0);

    // Same program, each report stalled 5 cycles; restart from DONE.
    rpt_ready_a = 1'b0;
    push_main_a();
    pulse_start_a();
    for (int r = 0; r < 4; r++) begin
      w = 0;
      while (!rpt_valid_a && w < 50) begin @(negedge clk); w++; end
      check("a_stall_valid_seen", int'(rpt_valid_a), 1);
      repeat (5) @(posedge clk);
      #1 rpt_ready_a = 1'b1;
      @(posedge clk);
      #1 rpt_ready_a = 1'b0;
    end
    rpt_ready_a = 1'b1;
    wait_done_a(n);
    check("a_stall_mem_addr", int'(mem_addr_a), 16);
    check("a_stall_overflow", int'(ovf_a), 0);
    check("a_stall_q_empty", qa.size(), 0);

    // Register 0 hazards counted when ZERO_HARD=0.
    for (int i = 0; i < 64; i++) mem_a[i] = 4'd0;
    put_a(0, 0, 0, 1, 2);  // ADD R0,R1,R2
    put_a(1, 2, 3, 0, 0);  // SUB R3,R0,R0
    mem_a[8] = 4'd4;
    qa.push_back(mk(0, 0, 0, 0, 4));
    qa.push_back(mk(1, 1, 0, 0, 8));
    pulse_start_a();
    wait_done_a(n);
    check("a_zero_mem_addr", int'(mem_addr_a), 8);
    check("a_zero_q_empty", qa.size(), 0);

    // Reset during FETCH of instruction 2, then a clean rerun.
    load_main_a();
    qa.push_back(mk(0, 0, 0, 0, 4));
    qa.push_back(mk(1, 1, 0, 0, 8));
    pulse_start_a();
    repeat (14) @(posedge clk);
    #1;
    check("a_prereset_busy", int'(busy_a), 1);
    check("a_prereset_mem_addr", int'(mem_addr_a), 10);
    rst_a_n = 1'b0;
    #1;
    check_zero_a("a_midrun_rst");
    check("a_midrun_q_empty", qa.size(), 0);
    @(posedge clk);
    #1 rst_a_n = 1'b1;
    push_main_a();
    pulse_start_a();
    wait_done_a(n);
    check("a_rerun_mem_addr", int'(mem_addr_a), 16);
    check("a_rerun_q_empty", qa.size(), 0);

    // END_OP at address 0: no report, DONE after the first FETCH edge.
    for (int i = 0; i < 64; i++) mem_a[i] = 4'd0;
    mem_a[0] = 4'd4;
    pulse_start_a();
    @(negedge clk);
    check("a_end0_busy_fetch", int'(busy_a), 1);
    check("a_end0_done_early", int'(done_a), 0);
    @(negedge clk);
    check("a_end0_done", int'(done_a), 1);
    check("a_end0_mem_addr", int'(mem_addr_a), 0);
    check("a_end0_busy", int'(busy_a), 0);
    check("a_end0_q_empty", qa.size(), 0);

    // ZERO_HARD=1: the same register-0 program yields no hazards.
    put_b(0, 0, 0, 1, 2);
    put_b(1, 2, 3, 0, 0);
    mem_b[8] = 4'd4;
    qb.push_back(mk(0, 0, 0, 0, 4));
    qb.push_back(mk(1, 0, 0, 0, 8));
    pulse_start_b();
    wait_done_b(n);
    check("b_zero_mem_addr", int'(mem_addr_b), 8);
    check("b_zero_overflow", int'(ovf_b), 0);
    check("b_zero_q_empty", qb.size(), 0);

    // No END_OP in a 16-word memory: 4 reports, then overflow.
    put_b(0, 1, 1, 2, 3);
    put_b(1, 2, 2, 1, 1);
    put_b(2, 3, 1, 2, 7);
    put_b(3, 0, 3, 1, 2);
    qb.push_back(mk(0, 0, 0, 0, 4));
    qb.push_back(mk(1, 1, 1, 0, 8));
    qb.push_back(mk(2, 1, 1, 2, 12));
    qb.push_back(mk(3, 7, 4, 0, 15));
    pulse_start_b();
    wait_done_b(n);
    check("b_ovf_latency", n, 25);
    check("b_ovf_overflow", int'(ovf_b), 1);
    check("b_ovf_mem_addr", int'(mem_addr_b), 15);
    check("b_ovf_busy", int'(busy_b), 0);
    check("b_ovf_q_empty", qb.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dep_window_checker.md
Name: dep_window_checker

Overview:
- Sequential hazard checker for the 4-field instruction stream: opcode, dest, src1, src2, one field per memory word.
- Fetches instructions one word per cycle from the instruction memory over the address/data port pair.
- Compares each new instruction against the last WINDOW instructions and reports RAW/WAR/WAW hazards per distance through a valid/ready report channel.
- Successor to the single-compare checker: adds parametrised field width, address width and window depth, an optional hardwired zero register, back-pressure and overflow detection.

Parameters:
- FIELD_W, 4, width of each instruction field and of mem_data.
- ADDR_W, 6, instruction memory address width.
- WINDOW, 3, number of previous instructions compared; must be at least 1.
- END_OP, 4, opcode value that terminates the program.
- ZERO_HARD, 0, when 1, register 0 never creates a hazard.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a run at address 0. Ignored unless in IDLE or DONE.
- mem_addr  out  ADDR_W  registered instruction memory address.
- mem_data  in  FIELD_W  combinational read data for mem_addr, sampled on the same edge.
- rpt_valid  out  1  report available.
- rpt_ready  in  1  consumer accepts the report.
- rpt_index  out  ADDR_W-2  index of the reported instruction (0-based).
- rpt_raw  out  WINDOW  bit k-1 set: RAW against the instruction k back.
- rpt_war  out  WINDOW  bit k-1 set: WAR against the instruction k back.
- rpt_waw  out  WINDOW  bit k-1 set: WAW against the instruction k back.
- busy  out  1  high in FETCH, CHECK and REPORT.
- done  out  1  high in DONE.
- overflow  out  1  set on entry to DONE when the address space ran out without END_OP.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; window valid bits cleared. Reset mid-run aborts immediately with no partial report.
- States: IDLE, FETCH, CHECK, REPORT, DONE.
- IDLE/DONE, start pulse: mem_addr<=0, field counter<=0, window cleared, overflow<=0, instruction index<=0, go to FETCH.
- FETCH: on each edge, capture mem_data into field[cnt], increment mem_addr, increment cnt.
  - If cnt==0 and mem_data==END_OP: go to DONE and do not increment mem_addr.
  - After field 3 is captured: go to CHECK.
- Overflow: if mem_addr==2^ADDR_W-1 when field 3 is captured, the final instruction is still checked and reported, then the FSM goes to DONE with overflow=1. mem_addr never wraps to 0.
- CHECK, one cycle, for each window slot k=1..WINDOW holding a valid previous instruction P:
  - RAW = (C.src1==P.dest) or (C.src2==P.dest).
  - WAR = (C.dest==P.src1) or (C.dest==P.src2).
  - WAW = (C.dest==P.dest).
  - Invalid slots give 0.
  - ZERO_HARD=1: any compare involving register value 0 gives 0.
  - Results are registered into the rpt_* outputs; rpt_valid<=1; go to REPORT.
- REPORT: rpt_* held stable while rpt_valid=1 and rpt_ready=0.
  - On rpt_valid and rpt_ready: rpt_valid<=0.
  - The window shifts: slot1<=C, slot k+1<=slot k, oldest entry dropped.
  - Index increments.
  - Next state is FETCH, or DONE if overflow is pending.
  - rpt_ready held high gives one report every 6 cycles per instruction: 4 FETCH + 1 CHECK + 1 REPORT.
- The END_OP opcode word is consumed but never reported; its other fields are not fetched.
- DONE holds until start or reset. A start in DONE restarts cleanly.
- start during busy: ignored.

Test Plan:
- Program ADD R5,R0,R1 / MUL R6,R2,R5 / SUB R5,R3,R6 / DIV R6,R5,R4 / END, WINDOW=3, rpt_ready=1 -> reports 0..3:
  - index 0: raw=000 war=000 waw=000
  - index 1: raw=001 war=000 waw=000
  - index 2: raw=001 war=001 waw=010
  - index 3: raw=101 war=001 waw=010
  - then done=1, overflow=0, mem_addr=16.
- Same program, rpt_ready low for 5 cycles on each report -> identical reports, rpt_* stable while stalled, no extra mem_addr change during REPORT.
- ZERO_HARD=1, program ADD R0,R1,R2 / SUB R3,R0,R0 / END -> index 1 raw=000; with ZERO_HARD=0 -> index 1 raw=001.
- No END_OP in the memory, ADDR_W=4 -> 4 reports, then done=1 and overflow=1, mem_addr=15.
- rst_n asserted during FETCH of instruction 2 -> all outputs 0 immediately. A following start reruns from address 0 with an empty window (index 0 report all zeros).
- END_OP at address 0 -> no report, done=1 one cycle after the first FETCH edge, mem_addr=0.
